// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side consumer.
// Holds the opcode, operand and instruction encodings plus reader FSM states.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic        [4:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } reader_state_t;

endpackage

// File: rtl/instr_reader_exec_alu.sv
// Combinational executor for one instruction: signed 32-bit operands, 64-bit result.
// DIV/MOD by zero yield a zero result with div_err_o raised.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr_i,
  output result_t      res_o,
  output logic         div_err_o
);

  result_t opA;
  result_t opB;
  result_t safeB;

  assign opA = {{32{instr_i.op_a[31]}}, instr_i.op_a};
  assign opB = {{32{instr_i.op_b[31]}}, instr_i.op_b};

  // A non-zero divisor keeps the divider well defined; the zero case is overridden below.
  assign safeB = (opB == 64'sd0) ? 64'sd1 : opB;

  always_comb begin
    res_o     = 64'sd0;
    div_err_o = 1'b0;
    case (instr_i.opc)
      ZERO:  res_o = 64'sd0;
      PASSA: res_o = opA;
      PASSB: res_o = opB;
      ADD:   res_o = opA + opB;
      SUB:   res_o = opA - opB;
      MULT:  res_o = opA * opB;
      DIV: begin
        if (opB == 64'sd0) begin
          div_err_o = 1'b1;
        end else begin
          res_o = opA / safeB;
        end
      end
      MOD: begin
        if (opB == 64'sd0) begin
          div_err_o = 1'b1;
        end else begin
          res_o = opA % safeB;
        end
      end
      default: res_o = 64'sd0;
    endcase
  end

endmodule

// File: rtl/instr_reader_exec.sv
// Read-side consumer of the instruction register: walks an address window,
// executes each instruction and streams the results out over valid/ready.
module instr_reader_exec
  import instr_register_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RES_W    = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(NUM_REGS)-1:0] start_addr,
  input  logic [$clog2(NUM_REGS):0]   count,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_REGS)-1:0] read_pointer,
  input  logic [66:0]                 instruction_word,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(NUM_REGS)-1:0] res_addr,
  output logic [2:0]                  res_opcode,
  output logic [RES_W-1:0]            result,
  output logic                        div_err
);

  localparam int AW = $clog2(NUM_REGS);

  reader_state_t  state_q, state_d;
  logic [AW-1:0]  curAddr_q, curAddr_d;
  logic [AW:0]    remaining_q, remaining_d;
  logic [AW-1:0]  readPtr_q, readPtr_d;
  logic [AW-1:0]  resAddr_q, resAddr_d;
  opcode_t        resOpc_q, resOpc_d;
  logic [RES_W-1:0] result_q, result_d;
  logic           divErr_q, divErr_d;

  instruction_t   instr;
  result_t        aluRes;
  logic           aluErr;
  logic [AW-1:0]  nextAddr;

  assign instr = instruction_t'(instruction_word);

  instr_alu u_alu (
    .instr_i   (instr),
    .res_o     (aluRes),
    .div_err_o (aluErr)
  );

  assign nextAddr = (curAddr_q == AW'(NUM_REGS - 1)) ? '0 : curAddr_q + AW'(1);

  // The pointer is loaded on the edge that enters FETCH so it is valid throughout FETCH and EXEC.
  always_comb begin
    state_d     = state_q;
    curAddr_d   = curAddr_q;
    remaining_d = remaining_q;
    readPtr_d   = readPtr_q;
    resAddr_d   = resAddr_q;
    resOpc_d    = resOpc_q;
    result_d    = result_q;
    divErr_d    = divErr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            curAddr_d   = start_addr;
            remaining_d = count;
            readPtr_d   = start_addr;
            state_d     = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        result_d  = RES_W'(aluRes);
        resAddr_d = curAddr_q;
        resOpc_d  = instr.opc;
        divErr_d  = aluErr;
        state_d   = OUT;
      end
      OUT: begin
        if (res_ready) begin
          remaining_d = remaining_q - (AW+1)'(1);
          curAddr_d   = nextAddr;
          if (remaining_q == (AW+1)'(1)) begin
            state_d = FIN;
          end else begin
            readPtr_d = nextAddr;
            state_d   = FETCH;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      curAddr_q   <= '0;
      remaining_q <= '0;
      readPtr_q   <= '0;
      resAddr_q   <= '0;
      resOpc_q    <= ZERO;
      result_q    <= '0;
      divErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      curAddr_q   <= curAddr_d;
      remaining_q <= remaining_d;
      readPtr_q   <= readPtr_d;
      resAddr_q   <= resAddr_d;
      resOpc_q    <= resOpc_d;
      result_q    <= result_d;
      divErr_q    <= divErr_d;
    end
  end

  assign busy         = (state_q == FETCH) || (state_q == EXEC) || (state_q == OUT);
  assign done         = (state_q == FIN);
  assign res_valid    = (state_q == OUT);
  assign read_pointer = readPtr_q;
  assign res_addr     = resAddr_q;
  assign res_opcode   = resOpc_q;
  assign result       = result_q;
  assign div_err      = divErr_q;

endmodule

// File: tb/tb_instr_reader_exec.sv
// Self-checking bench: a register-file model feeds the reader, a scoreboard
// queue holds expected results and a negedge monitor checks every handshake.
module tb_instr_reader_exec;
  import instr_register_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  start_addr;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic [4:0]  read_pointer;
  logic [66:0] instruction_word;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_addr;
  logic [2:0]  res_opcode;
  logic [63:0] result;
  logic        div_err;

  instr_reader_exec dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .start_addr       (start_addr),
    .count            (count),
    .busy             (busy),
    .done             (done),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_addr         (res_addr),
    .res_opcode       (res_opcode),
    .result           (result),
    .div_err          (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    opcode_t  opc;
    operand_t a;
    operand_t b;
    result_t  expRes;
    logic     expErr;
  } vec_t;

  typedef struct {
    logic [4:0] addr;
    opcode_t    opc;
    result_t    res;
    logic       err;
  } sb_t;

  instruction_t mem [32];
  result_t      expRes [32];
  logic         expErr [32];
  sb_t          sbQ [$];

  int checks     = 0;
  int failures   = 0;
  int hsCount    = 0;
  int doneCount  = 0;

  logic        stallHeld = 1'b0;
  logic [4:0]  heldAddr;
  logic [63:0] heldRes;
  logic [2:0]  heldOpc;
  logic        heldErr;

  assign instruction_word = mem[read_pointer];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, $signed(actual), $signed(expected));
    end
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [5:0] cnt);
    for (int k = 0; k < int'(cnt); k++) begin
      logic [4:0] a;
      sb_t e;
      a = addr + 5'(k);
      e.addr = a;
      e.opc  = mem[a].opc;
      e.res  = expRes[a];
      e.err  = expErr[a];
      sbQ.push_back(e);
    end
    start_addr = addr;
    count      = cnt;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles);
    int n = 0;
    while (!done && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("done_pulse_one_cycle", 64'(done), 64'd0);
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      stallHeld = 1'b0;
    end else begin
      if (done) doneCount++;
      if (stallHeld) begin
        checkOutput("stall_valid", 64'(res_valid), 64'd1);
        checkOutput("stall_addr", 64'(res_addr), 64'(heldAddr));
        checkOutput("stall_result", result, heldRes);
        checkOutput("stall_opcode", 64'(res_opcode), 64'(heldOpc));
        checkOutput("stall_div_err", 64'(div_err), 64'(heldErr));
      end
      if (res_valid && !res_ready) begin
        stallHeld = 1'b1;
        heldAddr  = res_addr;
        heldRes   = result;
        heldOpc   = res_opcode;
        heldErr   = div_err;
      end else begin
        stallHeld = 1'b0;
      end
      if (res_valid && res_ready) begin
        hsCount++;
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result: got addr %0d result %0d, required none", res_addr, $signed(result));
        end else begin
          sb_t e;
          e = sbQ.pop_front();
          checkOutput("sb_addr", 64'(res_addr), 64'(e.addr));
          checkOutput("sb_opcode", 64'(res_opcode), 64'(e.opc));
          checkOutput("sb_result", result, e.res);
          checkOutput("sb_div_err", 64'(div_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    vec_t vecs [14];
    int   hs0;
    int   dn0;
    int   n;

    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    res_ready  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = '{opc: ZERO, op_a: 32'sd0, op_b: 32'sd0};
      expRes[i] = 64'sd0;
      expErr[i] = 1'b0;
    end

    // Reset held with a start pulse present
    start      = 1'b1;
    start_addr = 5'd7;
    count      = 6'd5;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_read_pointer", 64'(read_pointer), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single read");
    mem[3]    = '{opc: ADD, op_a: -32'sd15, op_b: 32'sd7};
    expRes[3] = -64'sd8;
    applyStimulus(5'd3, 6'd1);
    checkOutput("single_rp_n1", 64'(read_pointer), 64'd3);
    checkOutput("single_busy_n1", 64'(busy), 64'd1);
    @(posedge clk); #1;
    checkOutput("single_valid_n2", 64'(res_valid), 64'd0);
    checkOutput("single_rp_n2", 64'(read_pointer), 64'd3);
    @(posedge clk); #1;
    checkOutput("single_valid_n3", 64'(res_valid), 64'd1);
    checkOutput("single_result_n3", result, -64'sd8);
    checkOutput("single_addr_n3", 64'(res_addr), 64'd3);
    checkOutput("single_err_n3", 64'(div_err), 64'd0);
    @(posedge clk); #1;
    checkOutput("single_done_n4", 64'(done), 64'd1);
    checkOutput("single_busy_n4", 64'(busy), 64'd0);
    @(posedge clk); #1;
    checkOutput("single_done_n5", 64'(done), 64'd0);

    $display("[TB] opcode table");
    vecs[0]  = '{ZERO,  -32'sd7, 32'sd2, 64'sd0,  1'b0};
    vecs[1]  = '{PASSA, -32'sd7, 32'sd2, -64'sd7, 1'b0};
    vecs[2]  = '{PASSB, -32'sd7, 32'sd2, 64'sd2,  1'b0};
    vecs[3]  = '{ADD,   -32'sd7, 32'sd2, -64'sd5, 1'b0};
    vecs[4]  = '{SUB,   -32'sd7, 32'sd2, -64'sd9, 1'b0};
    vecs[5]  = '{MULT,  -32'sd7, 32'sd2, -64'sd14, 1'b0};
    vecs[6]  = '{DIV,   -32'sd7, 32'sd2, -64'sd3, 1'b0};
    vecs[7]  = '{MOD,   -32'sd7, 32'sd2, -64'sd1, 1'b0};
    vecs[8]  = '{DIV,   32'sd9,  32'sd0, 64'sd0,  1'b1};
    vecs[9]  = '{MOD,   32'sd9,  32'sd4, 64'sd1,  1'b0};
    vecs[10] = '{DIV,   32'sh8000_0000, -32'sd1, 64'sd2147483648, 1'b0};
    vecs[11] = '{MULT,  32'sh7fff_ffff, -32'sd2, -64'sd4294967294, 1'b0};
    vecs[12] = '{MOD,   32'sd5,  32'sd0, 64'sd0,  1'b1};
    vecs[13] = '{MOD,   32'sd7,  -32'sd2, 64'sd1, 1'b0};
    for (int i = 0; i < 14; i++) begin
      mem[i]    = '{opc: vecs[i].opc, op_a: vecs[i].a, op_b: vecs[i].b};
      expRes[i] = vecs[i].expRes;
      expErr[i] = vecs[i].expErr;
    end
    for (int i = 0; i < 14; i++) begin
      applyStimulus(5'(i), 6'd1);
      waitDone(10);
    end
    applyStimulus(5'd0, 6'd14);
    waitDone(60);

    $display("[TB] wrap with backpressure");
    mem[30]    = '{opc: ADD, op_a: 32'sd100, op_b: 32'sd1};
    expRes[30] = 64'sd101;
    mem[31]    = '{opc: SUB, op_a: 32'sd5, op_b: 32'sd8};
    expRes[31] = -64'sd3;
    hs0 = hsCount;
    dn0 = doneCount;
    applyStimulus(5'd30, 6'd4);
    n = 0;
    while (hsCount == hs0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("wrap_first_hs", 64'(hsCount - hs0), 64'd1);
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("wrap_second_valid", 64'(res_valid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("wrap_stalled_hs", 64'(hsCount - hs0), 64'd1);
    res_ready = 1'b1;
    waitDone(40);
    checkOutput("wrap_hs_total", 64'(hsCount - hs0), 64'd4);
    checkOutput("wrap_done_total", 64'(doneCount - dn0), 64'd1);

    $display("[TB] count zero");
    hs0 = hsCount;
    applyStimulus(5'd5, 6'd0);
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    checkOutput("zero_valid", 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("zero_done_drop", 64'(done), 64'd0);
    checkOutput("zero_no_hs", 64'(hsCount - hs0), 64'd0);

    $display("[TB] start while busy");
    hs0 = hsCount;
    applyStimulus(5'd3, 6'd1);
    start_addr = 5'd0;
    count      = 6'd2;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(20);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("busy_start_idle", 64'(busy), 64'd0);
    checkOutput("busy_start_hs", 64'(hsCount - hs0), 64'd1);

    $display("[TB] reset in OUT");
    res_ready = 1'b0;
    applyStimulus(5'd4, 6'd3);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("rst_out_valid_before", 64'(res_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_out_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_out_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_done", 64'(done), 64'd0);
    checkOutput("rst_out_rp", 64'(read_pointer), 64'd0);
    reset = 1'b0;
    sbQ.delete();
    res_ready = 1'b1;
    dn0 = doneCount;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rst_out_no_done", 64'(doneCount - dn0), 64'd0);
    checkOutput("rst_out_idle_busy", 64'(busy), 64'd0);

    checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
